// File: rtl/decodificador_7seg_binario.sv
// decodificador_7seg_binario: recovers hex nibbles from a multiplexed active-low 7-segment bus.
// Define DECOD7_PUNTO_EN to also sample the decimal point (i_Punto) and report it per digit (o_Puntos).
module decodificador_7seg_binario #(
    parameter int N_DIG     = 4,
    parameter int N_ESTABLE = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [6:0]           i_Segmentos,
    input  logic [N_DIG-1:0]     i_Anodos,
`ifdef DECOD7_PUNTO_EN
    input  logic                 i_Punto,
    output logic [N_DIG-1:0]     o_Puntos,
`endif
    output logic [4*N_DIG-1:0]   o_Digitos,
    output logic [N_DIG-1:0]     o_Valido,
    output logic                 o_Error,
    output logic                 o_Listo
);
`ifdef DECOD7_PUNTO_EN
    localparam int W = N_DIG + 8;
    logic [W-1:0] entrada;
    assign entrada = {i_Punto, i_Anodos, i_Segmentos};
`else
    localparam int W = N_DIG + 7;
    logic [W-1:0] entrada;
    assign entrada = {i_Anodos, i_Segmentos};
`endif
    localparam logic [7:0]       MAX = 8'(N_ESTABLE);
    localparam logic [7:0]       OBJ = 8'(N_ESTABLE - 1);
    localparam logic [N_DIG-1:0] UNO = N_DIG'(1);

    // {recognised, nibble}
    function automatic logic [4:0] decodifica(input logic [6:0] s);
        case (s)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0001100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    logic [W-1:0]     muestra;
    logic [7:0]       cuenta;
    logic             capturado;
    logic [N_DIG-1:0] mascara;
    logic [N_DIG-1:0] sel;
    logic [N_DIG-1:0] mascara_sig;
    logic             igual;
    logic             captura;
    logic             uno_activo;
    logic             varios;
    logic [4:0]       patron;

    assign sel         = ~i_Anodos;
    assign igual       = entrada == muestra;
    assign captura     = igual && cuenta == OBJ && !capturado;
    assign uno_activo  = sel != '0 && (sel & (sel - UNO)) == '0;
    assign varios      = sel != '0 && !uno_activo;
    assign patron      = decodifica(i_Segmentos);
    assign mascara_sig = mascara | sel;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            muestra   <= '0;
            cuenta    <= '0;
            capturado <= 1'b0;
            mascara   <= '0;
            o_Digitos <= '0;
            o_Valido  <= '0;
            o_Error   <= 1'b0;
            o_Listo   <= 1'b0;
`ifdef DECOD7_PUNTO_EN
            o_Puntos  <= '0;
`endif
        end else begin
            muestra   <= entrada;
            cuenta    <= !igual ? 8'd0 : (cuenta == MAX ? cuenta : cuenta + 8'd1);
            capturado <= igual && (capturado || captura);
            o_Error   <= captura && (varios || (uno_activo && !patron[4]));
            o_Listo   <= captura && uno_activo && mascara_sig == '1;
            // Blank slots and multi-anode slots leave digits and frame mask alone
            if (captura && uno_activo) begin
                mascara <= mascara_sig == '1 ? '0 : mascara_sig;
                for (int i = 0; i < N_DIG; i++)
                    if (sel[i]) begin
                        o_Digitos[4*i +: 4] <= patron[4] ? patron[3:0] : 4'h0;
                        o_Valido[i]         <= patron[4];
`ifdef DECOD7_PUNTO_EN
                        o_Puntos[i]         <= ~i_Punto;
`endif
                    end
            end
        end
    end
endmodule

// File: tb/tb_decodificador_7seg_binario.sv
// tb_decodificador_7seg_binario: directed scans checked every cycle against a run-length bus model.
module tb_decodificador_7seg_binario;
    localparam int NE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        punto = 1'b1;
    logic [15:0] dig;
    logic [3:0]  val;
    logic        err;
    logic        lis;
`ifdef DECOD7_PUNTO_EN
    logic [3:0]  pts;
`endif

    int checks = 0, failures = 0, n_err = 0, n_lis = 0;

    logic [6:0] tabla [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    logic [6:0] pat_scan [4] = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b0111000};

    decodificador_7seg_binario #(.N_DIG(4), .N_ESTABLE(NE)) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Segmentos(seg),
        .i_Anodos(an),
`ifdef DECOD7_PUNTO_EN
        .i_Punto(punto),
        .o_Puntos(pts),
`endif
        .o_Digitos(dig),
        .o_Valido(val),
        .o_Error(err),
        .o_Listo(lis)
    );

    always #5 clk = ~clk;

    // Model: a value is captured on the edge where it has been seen NE+1 times in a row
    logic [11:0] prev, vec;
    int          run, ceros, d, hit;
    logic [15:0] m_dig;
    logic [3:0]  m_val, m_mask, m_pts;
    logic        m_err, m_lis;
    bit          armed = 0;

    always @(posedge clk) begin
`ifdef DECOD7_PUNTO_EN
        vec = {punto, an, seg};
`else
        vec = {1'b0, an, seg};
`endif
        m_err = 1'b0;
        m_lis = 1'b0;
        if (rst) begin
            armed = 1;
            run = 1;
            prev = '0;
            m_dig = '0; m_val = '0; m_mask = '0; m_pts = '0;
        end else begin
            run = (vec == prev) ? run + 1 : 1;
            prev = vec;
            if (run == NE + 1) begin
                ceros = 0;
                d = 0;
                for (int i = 0; i < 4; i++) if (!an[i]) begin ceros++; d = i; end
                if (ceros > 1) m_err = 1'b1;
                else if (ceros == 1) begin
                    hit = -1;
                    for (int j = 0; j < 16; j++) if (tabla[j] == seg) hit = j;
                    m_dig[4*d +: 4] = hit >= 0 ? 4'(hit) : 4'h0;
                    m_val[d] = hit >= 0;
                    m_err = hit < 0;
                    m_pts[d] = !punto;
                    m_mask[d] = 1'b1;
                    if (m_mask == 4'hF) begin m_lis = 1'b1; m_mask = '0; end
                end
            end
        end
        #1;
        if (lis === 1'b1) n_lis++;
        if (err === 1'b1) n_err++;
        if (armed) begin
            checks++;
            if ({dig, val, err, lis} !== {m_dig, m_val, m_err, m_lis}) begin
                failures++;
                $display("FAIL ciclo t=%0t dut dig=%h val=%b err=%b lis=%b modelo dig=%h val=%b err=%b lis=%b",
                         $time, dig, val, err, lis, m_dig, m_val, m_err, m_lis);
            end
`ifdef DECOD7_PUNTO_EN
            checks++;
            if (pts !== m_pts) begin
                failures++;
                $display("FAIL puntos t=%0t dut=%b modelo=%b", $time, pts, m_pts);
            end
`endif
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h esperado=%h", n, a, e);
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    int e0, l0;

    initial begin
        an = 4'b1110; seg = 7'b0010010; rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_salidas", {dig, val, err, lis}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_aun_no", val, 4'b0000);
        @(negedge clk);
        chk("t1_digito", dig[3:0], 4'h2);
        chk("t1_valido", val, 4'b0001);

        e0 = n_err;
        hold(4'b1101, 7'b0000110, 4);
        hold(4'b1111, 7'b1111111, 3);
        chk("t2_digitos", dig, 16'h0002);
        chk("t2_valido", val, 4'b0001);
        chk("t2_error", n_err - e0, 0);

        l0 = n_lis;
        for (int k = 0; k < 4; k++) hold(~(4'b0001 << k), pat_scan[k], 8);
        chk("t3_digitos", dig, 16'hF321);
        chk("t3_valido", val, 4'hF);
        chk("t3_listo1", n_lis - l0, 1);
        for (int k = 0; k < 4; k++) hold(~(4'b0001 << k), pat_scan[k], 8);
        chk("t3_listo2", n_lis - l0, 2);

        hold(4'b1011, 7'b0100100, 8);
        chk("t4_cinco", dig[11:8], 4'h5);
        e0 = n_err;
        hold(4'b1011, 7'b1111111, 8);
        chk("t4_digitos", dig, 16'hF021);
        chk("t4_valido", val, 4'b1011);
        chk("t4_error", n_err - e0, 1);

        e0 = n_err;
        hold(4'b1100, 7'b0000001, 8);
        chk("t5_multi_err", n_err - e0, 1);
        chk("t5_multi_dig", dig, 16'hF021);
        hold(4'b1111, 7'b1111111, 8);
        chk("t5_blanco_err", n_err - e0, 1);
        chk("t5_blanco_val", val, 4'b1011);

        hold(4'b0111, 7'b0000000, 4);
        hold(4'b1111, 7'b0000000, 2);
        chk("glitch_dig", dig, 16'hF021);

        hold(4'b0111, 7'b0000000, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_medio_dig", dig, 16'h0000);
        @(negedge clk);
        chk("rst_medio_cap", dig, 16'h8000);
        chk("rst_medio_val", val, 4'b1000);

`ifdef DECOD7_PUNTO_EN
        punto = 1'b0;
        hold(4'b1101, 7'b0000000, 6);
        chk("t6_dig", dig[7:4], 4'h8);
        chk("t6_punto_on", pts[1], 1'b1);
        punto = 1'b1;
        hold(4'b1101, 7'b0000000, 6);
        chk("t6_punto_off", pts[1], 1'b0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
